// File: rtl/mem_pkg.sv
// mem_pkg: shared size codes, FSM states and widths for the memory responder
package mem_pkg;
  localparam int DATA_W = 32;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, alignment check, read zero-extend and write lane replication
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [3:0]        be,
  output logic              misaligned,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata_rep
);
  logic [DATA_W-1:0] sh;
  always_comb begin
    misaligned = (size == SZ_RSVD) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    be = misaligned ? 4'b0000 :
         size == SZ_BYTE ? 4'b0001 << off :
         size == SZ_HALF ? 4'b0011 << off : 4'b1111;
    sh = rword >> {off, 3'b000};
    rdata = size == SZ_BYTE ? {24'h0, sh[7:0]} :
            size == SZ_HALF ? {16'h0, sh[15:0]} : sh;
    wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} :
                size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated byte/half/word RAM responder with one-cycle done pulse
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned
);
  localparam int CW = $clog2(LATENCY + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, a, base;
  logic we_q, we_d, w;
  logic [1:0] size_q, size_d, s;
  logic [DATA_W-1:0] wdata_q, wdata_d, wd, rdata_q, rdata_d, rword, rext, wrep;
  logic mis_q, mis_d, mis, commit;
  logic [3:0] be;
  logic [7:0] mem [2**ADDR_W];
  mem_lane_align u_align (
    .off(a[1:0]), .size(s), .wdata(wd), .rword(rword),
    .be(be), .misaligned(mis), .rdata(rext), .wdata_rep(wrep)
  );
  always_comb begin
    // with LATENCY==1 the accepting edge is also the commit edge, so use live inputs in IDLE
    a = state_q == ST_IDLE ? addr[ADDR_W-1:0] : addr_q;
    w = state_q == ST_IDLE ? we : we_q;
    s = state_q == ST_IDLE ? size : size_q;
    wd = state_q == ST_IDLE ? wdata : wdata_q;
    base = {a[ADDR_W-1:2], 2'b00};
    rword = {mem[base + ADDR_W'(3)], mem[base + ADDR_W'(2)], mem[base + ADDR_W'(1)], mem[base]};
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    we_d = we_q;
    size_d = size_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: if (req) begin
        addr_d = addr[ADDR_W-1:0];
        we_d = we;
        size_d = size;
        wdata_d = wdata;
        cnt_d = CW'(LATENCY - 1);
        state_d = LATENCY == 1 ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? ST_RESP : ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
    commit = state_d == ST_RESP && state_q != ST_RESP;
    rdata_d = commit && !w && !mis ? rext : rdata_q;
    mis_d = commit ? mis : mis_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      size_q <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      we_q <= we_d;
      size_q <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q <= mis_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && commit && w)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[base + ADDR_W'(b)] <= wrep[8*b +: 8];
  end
  assign rdata = rdata_q;
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_RESP;
  assign misaligned = done && mis_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven check of the memory responder plus streaming and reset-in-wait sequences
module tb_mem_responder;
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic busy, done, misaligned;
  int total = 0, bad = 0;
  typedef struct {
    logic we;
    logic [1:0] size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic mis;
  } vec_t;
  vec_t v[18];
  mem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .misaligned(misaligned)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic access(input string nm, input vec_t t);
    int n;
    logic got;
    @(negedge clk);
    req = 1'b1; we = t.we; size = t.size; addr = t.addr; wdata = t.wdata;
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      req = 1'b0;
      n++;
      if (done) got = 1'b1;
      else chk({nm, "_busy_wait"}, 32'(busy), 32'd1);
    end
    chk({nm, "_latency"}, 32'(n), 32'd2);
    chk({nm, "_busy_resp"}, 32'(busy), 32'd1);
    chk({nm, "_rdata"}, rdata, t.rd);
    chk({nm, "_mis"}, 32'(misaligned), 32'(t.mis));
  endtask
  initial begin
    v[0]  = '{1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
    v[1]  = '{1'b0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b1, 2'b00, 32'h12, 32'h55,       32'hDEADBEEF, 1'b0};
    v[3]  = '{1'b0, 2'b10, 32'h10, 32'h0,        32'hDE55BEEF, 1'b0};
    v[4]  = '{1'b0, 2'b00, 32'h13, 32'h0,        32'h000000DE, 1'b0};
    v[5]  = '{1'b0, 2'b01, 32'h11, 32'h0,        32'h000000DE, 1'b1};
    v[6]  = '{1'b1, 2'b10, 32'h12, 32'hFFFFFFFF, 32'h000000DE, 1'b1};
    v[7]  = '{1'b0, 2'b10, 32'h10, 32'h0,        32'hDE55BEEF, 1'b0};
    v[8]  = '{1'b0, 2'b10, 32'hFFFFFF10, 32'h0,  32'hDE55BEEF, 1'b0};
    v[9]  = '{1'b0, 2'b11, 32'h10, 32'h0,        32'hDE55BEEF, 1'b1};
    v[10] = '{1'b1, 2'b01, 32'h16, 32'hABCD1234, 32'hDE55BEEF, 1'b0};
    v[11] = '{1'b0, 2'b01, 32'h16, 32'h0,        32'h00001234, 1'b0};
    v[12] = '{1'b1, 2'b00, 32'h11, 32'h77,       32'h00001234, 1'b0};
    v[13] = '{1'b0, 2'b10, 32'h10, 32'h0,        32'hDE5577EF, 1'b0};
    v[14] = '{1'b1, 2'b10, 32'h20, 32'hCAFEF00D, 32'hDE5577EF, 1'b0};
    v[15] = '{1'b0, 2'b01, 32'h22, 32'h0,        32'h0000CAFE, 1'b0};
    v[16] = '{1'b1, 2'b00, 32'h1FF, 32'hA5,      32'h0000CAFE, 1'b0};
    v[17] = '{1'b0, 2'b00, 32'hFF, 32'h0,        32'h000000A5, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_mis", 32'(misaligned), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 18; i++) access($sformatf("vec%0d", i), v[i]);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("stream_done%0d", i), 32'(done), 32'(i % 3 == 1));
      chk($sformatf("stream_busy%0d", i), 32'(busy), 32'(i % 3 != 2));
    end
    req = 1'b0;
    chk("stream_rdata", rdata, 32'hDE5577EF);
    @(negedge clk);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    chk("rst_wait_busy", 32'(busy), 32'd1);
    chk("rst_wait_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_after_busy", 32'(busy), 32'd0);
    chk("rst_after_done", 32'(done), 32'd0);
    chk("rst_after_rdata", rdata, 32'h0);
    chk("rst_after_mis", 32'(misaligned), 32'd0);
    @(negedge clk);
    chk("rst_later_done", 32'(done), 32'd0);
    access("rst_readback", '{1'b0, 2'b10, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
